// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, register address width and the zero register.
package riscv_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 0;
  typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/pend_counter.sv
// Saturating up/down count of in-flight writes to one architectural register.
module pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PEND_W-1:0] count,
  output logic              full,
  output logic              underflow
);
  logic [PEND_W-1:0] count_q, count_d;

  assign full  = (count_q == '1);
  assign count = count_q;

  // A simultaneous issue and write-back cancel; clr wins over both.
  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (!full) count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q == '0) underflow = 1'b1;
      else               count_d   = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass and per-register pending-write scoreboard.
module regfile_scoreboard #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic            use1,
  input  logic            use2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall,
  output logic            err
);
  import riscv_pkg::*;

  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [XLEN-1:0]   regs_q [NREG];
  logic [PEND_W-1:0] cnt    [NREG];
  logic [NREG-1:0]   full_vec;
  logic [NREG-1:0]   uf_vec;
  logic              err_q, err_d;
  logic              wb_live;

  assign wb_live = wb_en && (wb_addr != ZERO_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (wb_live) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign cnt[0]      = '0;
  assign full_vec[0] = 1'b0;
  assign uf_vec[0]   = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    pend_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (issue_en && (issue_rd == AW'(r))),
      .dec      (wb_en && (wb_addr == AW'(r))),
      .clr      (flush),
      .count    (cnt[r]),
      .full     (full_vec[r]),
      .underflow(uf_vec[r])
    );
  end

  assign issue_ready = !full_vec[issue_rd];

  assign err_d = err_q || (|uf_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    if (a == ZERO_A)                       return '0;
    else if (rst_n && wb_en && wb_addr == a) return wb_data;
    else                                   return regs_q[a];
  endfunction

  // A single outstanding write resolves in the same cycle its write-back arrives.
  function automatic logic busy(input logic used, input logic [AW-1:0] a);
    logic [PEND_W-1:0] c;
    c = cnt[a];
    if (!used || a == ZERO_A) return 1'b0;
    if (c > PEND_W'(1))       return 1'b1;
    return (c == PEND_W'(1)) && !(wb_en && wb_addr == a);
  endfunction

  always_comb begin
    rd1   = read_port(a1);
    rd2   = read_port(a2);
    stall = busy(use1, a1) || busy(use2, a2);
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed test of regfile_scoreboard against a behavioural register/pending-count model.
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int PMAX = 3;

  logic            clk, rst_n;
  logic [AW-1:0]   a1, a2, issue_rd, wb_addr;
  logic            use1, use2, issue_en, wb_en, flush;
  logic [XLEN-1:0] rd1, rd2, wb_data;
  logic            issue_ready, stall, err;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [NREG];
  int          m_cnt  [NREG];
  logic        m_err;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .PEND_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .use1(use1), .use2(use2),
    .rd1(rd1), .rd2(rd2), .issue_en(issue_en), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: architectural state updated from the rules, not from RTL structure.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
      m_err = 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        bit iss, wb;
        iss = issue_en && issue_rd == AW'(r);
        wb  = wb_en && wb_addr == AW'(r);
        if (flush)           m_cnt[r] = 0;
        else if (iss && wb)  ;
        else if (iss)        begin if (m_cnt[r] < PMAX) m_cnt[r]++; end
        else if (wb)         begin if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r]--; end
      end
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    end
  end

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    if (a == 0 || !rst_n) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic u, input logic [AW-1:0] a);
    int c;
    c = m_cnt[a];
    if (!u || a == 0) return 1'b0;
    if (c >= 2) return 1'b1;
    return c == 1 && !(wb_en && wb_addr == a);
  endfunction

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("rd1", rd1, m_read(a1));
      chk("rd2", rd2, m_read(a2));
      chk("stall", {31'd0, stall}, {31'd0, m_busy(use1, a1) || m_busy(use2, a2)});
      chk("issue_ready", {31'd0, issue_ready}, {31'd0, issue_rd == 0 || m_cnt[issue_rd] != PMAX});
      chk("err", {31'd0, err}, {31'd0, m_err});
    end
  end

  task automatic idle();
    a1 = '0; a2 = '0; use1 = 0; use2 = 0; issue_en = 0; issue_rd = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic issue(input logic [AW-1:0] r);
    issue_en = 1; issue_rd = r; tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // Bypass must stay inactive during reset.
    wb_en = 1; wb_addr = 5; wb_data = 32'hFF; a1 = 5;
    #2 chk("reset_bypass_off", rd1, 32'h0);
    tick();
    cmp_on = 1'b1;
    tick();
    rst_n = 1'b1;

    // Reset and zero register
    wb_en = 1; wb_addr = 0; wb_data = 32'hDEADBEEF; a1 = 0;
    #2 chk("x0_write_rd", rd1, 32'h0);
    tick();
    a1 = 0; a2 = 5;
    #2 chk("x0_after", rd1, 32'h0);
    chk("x5_reset", rd2, 32'h0);
    chk("err_init", {31'd0, err}, 32'h0);

    // Bypass
    tick();
    wb_en = 1; wb_addr = 7; wb_data = 32'h1234; a2 = 7;
    #2 chk("bypass_rd2", rd2, 32'h1234);
    tick();
    a2 = 7;
    #2 chk("x7_stored", rd2, 32'h1234);

    // RAW stall on x3
    tick();
    issue(3);
    use1 = 1; a1 = 3;
    #2 chk("raw_stall", {31'd0, stall}, 32'd1);
    tick();
    use1 = 1; a1 = 3; wb_en = 1; wb_addr = 3; wb_data = 32'h55;
    #2 chk("raw_wb_stall", {31'd0, stall}, 32'd0);
    chk("raw_wb_rd1", rd1, 32'h55);
    tick();

    // WAW, two in flight on x4
    issue(4);
    issue(4);
    use1 = 1; a1 = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h1;
    #2 chk("waw_first_wb", {31'd0, stall}, 32'd1);
    tick();
    use1 = 1; a1 = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h2;
    #2 chk("waw_second_wb", {31'd0, stall}, 32'd0);
    chk("waw_rd1", rd1, 32'h2);
    tick();

    // Saturation on x9
    issue(9); issue(9); issue(9);
    issue_rd = 9;
    #2 chk("sat_ready", {31'd0, issue_ready}, 32'd0);
    chk("model_cnt9", m_cnt[9], 32'd3);
    issue(9);
    issue_rd = 9; use2 = 1; a2 = 9;
    #2 chk("sat_no_wrap", {31'd0, issue_ready}, 32'd0);
    chk("sat_stall", {31'd0, stall}, 32'd1);
    issue_en = 1; issue_rd = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    tick();
    issue_rd = 9;
    #2 chk("sat_iss_wb", {31'd0, issue_ready}, 32'd0);
    issue_rd = 0;
    #1 chk("x0_ready", {31'd0, issue_ready}, 32'd1);

    // Flush and underflow
    tick();
    issue(2);
    issue(6);
    flush = 1; issue_en = 1; issue_rd = 8;
    tick();
    issue_rd = 8; use1 = 1; a1 = 8; use2 = 1; a2 = 6;
    #2 chk("flush_x8", {31'd0, stall}, 32'd0);
    chk("flush_ready8", {31'd0, issue_ready}, 32'd1);
    issue_rd = 9;
    #1 chk("flush_ready9", {31'd0, issue_ready}, 32'd1);
    chk("model_cnt6", m_cnt[6], 32'd0);
    tick();
    wb_en = 1; wb_addr = 6; wb_data = 32'h66;
    tick();
    a1 = 6; use1 = 1; issue_rd = 6;
    #2 chk("uf_err", {31'd0, err}, 32'd1);
    chk("uf_rd", rd1, 32'h66);
    chk("uf_cnt0", {31'd0, stall}, 32'd0);
    tick();
    tick();
    #2 chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset mid-operation
    issue(5);
    issue(5);
    use1 = 1; a1 = 5;
    #2 chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd7", {31'd0, 1'b0} | 32'(rd1), 32'h0);
    tick();
    rst_n = 1'b1;
    a1 = 7;
    #2 chk("rst_x7_cleared", rd1, 32'h0);
    tick();
    tick();

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file with built-in scoreboard, for the pipelined RISC-V core. It provides two combinational read ports with write-to-read bypass and one synchronous write-back port. A per-register pending-write counter marks results still in flight, and the block raises `stall` when a decode-stage source operand is not yet available. Register 0 is hard-wired to zero: it is never written and never marked pending.

## Interface
Parameters:
- `XLEN`, 32, data width of every register.
- `NREG`, 32, number of architectural registers, power of two, at least 2.
- `AW`, $clog2(NREG), width of register addresses.
- `PEND_W`, 2, width of each pending counter; at most 2^PEND_W−1 writes in flight per register.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `a1`, `a2`  in  AW  source register addresses.
- `use1`, `use2`  in  1  the decoded instruction actually reads `a1` / `a2`.
- `rd1`, `rd2`  out  XLEN  source data, bypassed.
- `issue_en`  in  1  the instruction in decode issues and will write `issue_rd`.
- `issue_rd`  in  AW  destination register of the issuing instruction.
- `issue_ready`  out  1  the counter for `issue_rd` is below its maximum.
- `wb_en`  in  1  write-back valid.
- `wb_addr`  in  AW  write-back destination register.
- `wb_data`  in  XLEN  write-back value.
- `flush`  in  1  kill all in-flight instructions; clears every counter.
- `stall`  out  1  a used source register has an unresolved pending write.
- `err`  out  1  sticky flag: write-back arrived for a register whose counter was 0.

## Operation
- **Storage.** `regs[NREG]` of XLEN bits and `cnt[NREG]` of PEND_W bits. Reset clears both arrays to 0 and clears `err`.
- **Write.** On a rising edge with `wb_en` high and `wb_addr` ≠ 0, `regs[wb_addr]` ← `wb_data`.
- **Read.** `rdN` = `wb_data` when `wb_en` is high, `wb_addr` equals `aN`, and `aN` ≠ 0. Otherwise `rdN` = `regs[aN]`. `rdN` = 0 whenever `aN` = 0.
- **Counter update per edge, for each register r ≠ 0, in priority order:**
  - `flush` high: `cnt[r]` ← 0. Any concurrent issue is ignored; a concurrent write-back still writes `regs`.
  - Issue to r together with write-back to r: `cnt[r]` unchanged.
  - Issue to r alone: `cnt[r]` + 1. This is accepted only when `issue_ready` is high; otherwise it is ignored with no wrap-around.
  - Write-back to r alone: `cnt[r]` − 1. If `cnt[r]` is 0, it stays 0 and `err` ← 1.
- `issue_rd` = 0 never changes any counter, and `issue_ready` is 1 for it.
- `issue_ready` = (`cnt[issue_rd]` ≠ 2^PEND_W−1) or (`issue_rd` = 0).
- **Source availability.** For each N, `busyN` = `useN` and `aN` ≠ 0 and (`cnt[aN]` > 1, or (`cnt[aN]` = 1 and not (`wb_en` and `wb_addr` = `aN`))).
- `stall` = `busy1` or `busy2`. It is combinational and not gated by `flush`; the pipeline controller gives `flush` priority.
- While `stall` is high, the controller must hold `issue_en` low. The block does not check this.

## Timing
- Reads, bypass, `stall` and `issue_ready` are purely combinational from current state and inputs, with zero latency.
- Writes and counter updates take effect at the rising edge. A read in the following cycle returns the new value without bypass.
- `rst_n` low forces state immediately, independent of `clk`: `rd1` = `rd2` = 0 (bypass inactive during reset), `stall` = 0, `issue_ready` = 1, `err` = 0.
- Reset released mid-operation: all in-flight state is lost. The pipeline is also reset.
- `err` is cleared only by reset.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `REG_AW`, `ZERO_REG` = 0, and type `xlen_t`.
- One sub-module, `pend_counter`: a PEND_W-bit saturating up/down counter with inputs `inc`, `dec` and `clr`, and outputs `count`, `full` and `underflow`. It is instantiated once for each of registers 1..NREG−1.
- The data array is plain flops with asynchronous clear. There is no RAM macro, because reset must clear it.

## Test plan
- **Reset and zero register:** release reset, then write 0xDEADBEEF to x0 → `rd1` = 0 for `a1` = 0. Every `rd` for `a1` = 5 is 0, `stall` = 0 and `err` = 0.
- **Bypass:** `wb_en`=1, `wb_addr`=7, `wb_data`=0x1234, `a2`=7 → `rd2` = 0x1234 in the same cycle, and `regs[7]` = 0x1234 after the edge.
- **RAW stall:** issue to x3, then `use1`=1 with `a1`=3 → `stall`=1. In the write-back cycle for x3 (data 0x55), `stall`=0 and `rd1`=0x55.
- **WAW with two in flight:** issue to x4 twice, so `cnt`=2. The first write-back to x4 keeps `stall`=1 for `a1`=4. The second write-back clears it.
- **Saturation and simultaneous events:** issue to x9 three times with PEND_W=2 → `issue_ready`=0 and a fourth issue leaves `cnt`=3. An issue and write-back to x9 in the same cycle leaves `cnt` at 3.
- **Flush and underflow:** with x2 and x6 pending, assert `flush` together with an issue to x8 → all counters are 0 and x8 is not pending. A following write-back to x6 writes the register, sets `err`=1, and leaves `cnt[6]`=0.
